reg_wb_queue: RTL and testbench

- Write-back side of the register file: collects register write requests from the memory-load path and the ALU path, and queues them in order.
- Drives the register file's single write port, at most one write per clock.
- Exposes a youngest-match forwarding lookup so readers see values that are still pending.
- Sits between the EX/MEM write-back outputs and the register file write port (RegWrite / write_reg / write_data).

---
 rtl/mips_pkg.sv | 12 +
 rtl/reg_wb_queue_if.sv | 49 ++++
 rtl/reg_wb_queue_fwd_match.sv | 34 +++
 rtl/reg_wb_queue.sv | 90 +++++++++
 tb/tb_reg_wb_queue.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-back entry type
// used by the write-back queue and its forwarding search.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_queue_if.sv
// Write-back request, register-file write port and
// forwarding lookup bundle for reg_wb_queue.
interface reg_wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              wb_hold;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] fwd_reg_1;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic [ADDR_W-1:0] fwd_reg_2;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic [CW-1:0]     count;

  modport master (
    output mem_valid, mem_reg, mem_data,
    output alu_valid, alu_reg, alu_data,
    output wb_hold, fwd_reg_1, fwd_reg_2,
    input  mem_ready, alu_ready,
    input  RegWrite, write_reg, write_data,
    input  fwd_hit_1, fwd_data_1,
    input  fwd_hit_2, fwd_data_2, count
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data,
    input  alu_valid, alu_reg, alu_data,
    input  wb_hold, fwd_reg_1, fwd_reg_2,
    output mem_ready, alu_ready,
    output RegWrite, write_reg, write_data,
    output fwd_hit_1, fwd_data_1,
    output fwd_hit_2, fwd_data_2, count
  );
endinterface

// File: rtl/reg_wb_queue_fwd_match.sv
// Youngest-match search over the occupied queue entries;
// the last hit in age order (nearest tail) wins.
module reg_wb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                 ent_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]  head_i,
  input  logic [$clog2(DEPTH):0]    count_i,
  input  logic [REG_ADDR_W-1:0]     reg_i,
  output logic                      hit_o,
  output logic [REG_DATA_W-1:0]     data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (CW'(i) < count_i &&
          reg_i != REG_ZERO &&
          ent_i[idx].rd == reg_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the single register-file
// write port, with two youngest-match forwarding lookups.
module reg_wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_wb_queue_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  wb_entry_t     ent_q [DEPTH];

  logic mem_push, alu_push, pop, empty;
  logic [PW-1:0] alu_slot;

  // Space is judged on the registered count only, so a pop
  // this cycle never frees room for a push this cycle.
  assign free  = CW'(DEPTH) - count_q;
  assign empty = (count_q == '0);

  assign wb.mem_ready = (free >= CW'(1));
  assign wb.alu_ready = (free >= CW'(2)) ||
                        ((free >= CW'(1)) && !wb.mem_valid);

  assign mem_push = wb.mem_valid && wb.mem_ready &&
                    (wb.mem_reg != ADDR_W'(0));
  assign alu_push = wb.alu_valid && wb.alu_ready &&
                    (wb.alu_reg != ADDR_W'(0));
  assign pop      = !empty && !wb.wb_hold;
  assign alu_slot = tail_q + PW'(mem_push);

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
    count_d = count_q + CW'(mem_push) + CW'(alu_push)
            - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push)
      ent_q[tail_q] <= '{rd: wb.mem_reg, data: wb.mem_data};
    if (alu_push)
      ent_q[alu_slot] <= '{rd: wb.alu_reg, data: wb.alu_data};
  end

  assign wb.RegWrite   = pop;
  assign wb.write_reg  = empty ? '0 : ent_q[head_q].rd;
  assign wb.write_data = empty ? '0 : ent_q[head_q].data;
  assign wb.count      = count_q;

  reg_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_1 (
    .ent_i   (ent_q),
    .head_i  (head_q),
    .count_i (count_q),
    .reg_i   (wb.fwd_reg_1),
    .hit_o   (wb.fwd_hit_1),
    .data_o  (wb.fwd_data_1)
  );

  reg_wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_2 (
    .ent_i   (ent_q),
    .head_i  (head_q),
    .count_i (count_q),
    .reg_i   (wb.fwd_reg_2),
    .hit_o   (wb.fwd_hit_2),
    .data_o  (wb.fwd_data_2)
  );
endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed scenarios then random
// traffic, all checked against a queue-based reference.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  bit   chk_en;
  int   n_chk;
  int   n_err;
  ent_t q[$];

  reg_wb_queue_if #(.DEPTH(DEPTH)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic void lookup(input logic [4:0] f,
                                 output bit h,
                                 output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (f != 0)
      foreach (q[i])
        if (q[i].rd == f) begin
          h = 1'b1;
          d = q[i].d;
        end
  endfunction

  task automatic step(input bit rst,
                      input bit mv, input logic [4:0] mr,
                      input logic [31:0] md,
                      input bit av, input logic [4:0] ar,
                      input logic [31:0] ad,
                      input bit hold,
                      input logic [4:0] f1,
                      input logic [4:0] f2);
    int  free;
    bit  e_mr, e_ar, e_rw, h;
    logic [31:0] d;
    @(negedge clk);
    rst_n         = rst;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.wb_hold   = hold;
    bus.fwd_reg_1 = f1;
    bus.fwd_reg_2 = f2;
    #1;
    free = DEPTH - q.size();
    e_mr = free >= 1;
    e_ar = free >= 2 || (free >= 1 && !mv);
    e_rw = q.size() != 0 && !hold;
    if (chk_en) begin
      check("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
      check("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
      check("RegWrite", 64'(bus.RegWrite), 64'(e_rw));
      check("write_reg", 64'(bus.write_reg),
            q.size() != 0 ? 64'(q[0].rd) : 64'(0));
      check("write_data", 64'(bus.write_data),
            q.size() != 0 ? 64'(q[0].d) : 64'(0));
      check("count", 64'(bus.count), 64'(q.size()));
      lookup(f1, h, d);
      check("fwd_hit_1", 64'(bus.fwd_hit_1), 64'(h));
      check("fwd_data_1", 64'(bus.fwd_data_1), 64'(d));
      lookup(f2, h, d);
      check("fwd_hit_2", 64'(bus.fwd_hit_2), 64'(h));
      check("fwd_data_2", 64'(bus.fwd_data_2), 64'(d));
    end
    if (!rst) begin
      q.delete();
    end else begin
      if (e_rw) void'(q.pop_front());
      if (mv && e_mr && mr != 0) q.push_back('{mr, md});
      if (av && e_ar && ar != 0) q.push_back('{ar, ad});
    end
  endtask

  task automatic idle(input bit hold,
                      input logic [4:0] f1,
                      input logic [4:0] f2);
    step(1, 0, 0, 0, 0, 0, 0, hold, f1, f2);
  endtask

  task automatic alu(input logic [4:0] r,
                     input logic [31:0] d,
                     input bit hold);
    step(1, 0, 0, 0, 1, r, d, hold, r, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    chk_en = 0;
    rst_n = 1'b0;
    bus.mem_valid = 0; bus.mem_reg = 0; bus.mem_data = 0;
    bus.alu_valid = 0; bus.alu_reg = 0; bus.alu_data = 0;
    bus.wb_hold = 0; bus.fwd_reg_1 = 0; bus.fwd_reg_2 = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 8, 3);

    step(1, 1, 8, 32'hAA, 0, 0, 0, 0, 8, 0);
    idle(0, 8, 0);
    idle(0, 8, 0);

    step(1, 1, 3, 32'h11, 1, 3, 32'h22, 0, 3, 0);
    idle(1, 3, 3);
    idle(0, 3, 0);
    idle(0, 3, 0);
    idle(0, 3, 0);

    for (int i = 1; i <= 4; i++) alu(5'(i), 32'(i * 16), 1);
    step(1, 1, 9, 32'h99, 1, 10, 32'hA0, 1, 2, 4);
    for (int i = 0; i < 7; i++)
      step(1, 0, 0, 0, i < 3, 5'(12 + i), 32'(i + 7),
           0, 5'(1 + i), 13);
    for (int i = 0; i < 3; i++) idle(0, 12, 14);

    for (int i = 0; i < 3; i++) alu(5'(20 + i), 32'(i), 1);
    step(1, 1, 7, 32'h77, 1, 6, 32'h66, 1, 7, 6);
    for (int i = 0; i < 5; i++) idle(0, 7, 6);

    step(1, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0);
    idle(0, 0, 0);

    for (int i = 0; i < 3; i++) alu(5'(25 + i), 32'(i + 1), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 25, 27);
    for (int i = 0; i < 3; i++) idle(0, 25, 27);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) != 0,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
